inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage of the 24-bit CPU, directly upstream of decode/execute. It generates sequential PCs, issues reads to the synchronous instruction memory and buffers returned instructions with their PCs in a small prefetch FIFO. Decode drains the FIFO through a valid/ready handshake. Decode can redirect the fetch stream on jumps and taken branches, and can stop it on halt.

## Interface
Parameters:
- PC_W, 32, PC and instruction-memory address width
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)

Ports:
- ck  input  1  clock; one clock domain, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- imem_req  output  1  read request to instruction memory
- imem_addr  output  PC_W  read address (word address)
- imem_rdata  input  24  instruction data, valid exactly one cycle after imem_req
- inst_valid  output  1  FIFO head holds an instruction
- inst_ready  input  1  decode accepts head this cycle
- inst  output  24  head instruction
- inst_pc  output  PC_W  PC of head instruction
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  PC_W  restart target
- halt_req  input  1  stop issuing new fetches (sticky)
- halted  output  1  fetch stopped, FIFO empty, nothing in flight

## Operation
- State: fetch_pc, inflight flag (request issued last cycle), FIFO of {inst, pc}, count, stop flag.
- Issue rule: imem_req=1 when !stop && !redirect_valid && count + inflight < DEPTH. imem_addr=fetch_pc. On issue, fetch_pc <= fetch_pc+1 mod 2^PC_W. The wrap from all-ones to 0 is silent.
- Response: if inflight and not killed, push {imem_rdata, pc_of_request} into FIFO.
- Pop: inst_valid && inst_ready removes the head. inst and inst_pc come from the head. Their value when inst_valid=0 is don't-care but must be stable.
- Redirect (highest priority):
  - clear FIFO.
  - kill any response arriving this cycle.
  - ignore a same-cycle pop.
  - fetch_pc <= redirect_pc.
  - first request to redirect_pc is issued the following cycle.
- halt_req: sets stop. In-flight response is still pushed, and the FIFO keeps draining. stop is cleared only by reset. A redirect while stopped updates fetch_pc but issues nothing.
- halted = stop && count==0 && !inflight.
- Overflow is impossible by the credit rule. Push while full is an assertion failure.

## Timing
- Reset values: imem_req 0, imem_addr 0, inst_valid 0, inst 0, inst_pc 0, halted 0. Internal state on reset: fetch_pc 0, FIFO empty, stop 0, inflight 0.
- First rising edge after rst_n release: imem_req=1, imem_addr=0.
- Request in cycle N → data sampled and pushed at end of N+1 → inst_valid=1 in cycle N+2. Minimum fetch-to-decode latency is 2 cycles.
- With inst_ready held 1, throughput is one instruction per cycle.
- Redirect in cycle R:
  - inst_valid=0 in R+1.
  - request to redirect_pc in R+1.
  - that instruction is valid in R+3.
- Simultaneous push and pop in the same cycle: count unchanged.

## Configuration
- FETCH_HALT_DETECT_EN:
  - Defined: fetch predecodes each pushed instruction. When an instruction has optype 2'b11 and op 4'b1111 (halt), it is pushed normally and sets stop in the same cycle. No further requests issue after that cycle; one already in flight is killed.
  - Undefined: fetch stops only via halt_req, and instructions after a halt are prefetched and later flushed by decode.

## Structure
- Package cpu_pkg holds:
  - INST_W=24.
  - optype enum: OPT_ALU=2'b00, OPT_IMM=2'b01, OPT_JMP=2'b10, OPT_CTL=2'b11.
  - OP_HALT=4'b1111, OP_NOP=4'b0000.
  - field slice constants for optype/op/rd/rs/rt.
- One sub-module: fetch_fifo (DEPTH × {INST_W+PC_W}), with push/pop/flush, count, full/empty.

## Test plan
- Reset release, memory[k]=k, inst_ready=1:
  - imem_addr 0,1,2,… one per cycle.
  - inst_valid first high 2 cycles after the first request.
  - inst/inst_pc = (0,0),(1,1),(2,2)….
- inst_ready=0 for 10 cycles:
  - exactly DEPTH=4 instructions buffered.
  - imem_req drops.
  - releasing ready delivers pcs 0..3 then 4 with no gap and no duplicates.
- redirect_valid with redirect_pc=0x40 while FIFO holds 3 entries and a response is in flight:
  - next inst_valid is 0 for 2 cycles.
  - next delivered inst_pc is 0x40.
  - no stale pc appears.
- halt_req mid-stream:
  - no new imem_req afterward.
  - the in-flight response is delivered.
  - halted=1 once the FIFO has drained.
  - a later redirect does not restart fetch.
- FETCH_HALT_DETECT_EN defined, memory[2]=24'b11_1111_000000_000000_000000:
  - pcs 0,1,2 delivered.
  - no request beyond address 3.
  - halted=1 after draining.
- PC_W=4 with fetch_pc started at 0xE via redirect: addresses 0xE,0xF,0x0,0x1 delivered in order.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit CPU: instruction width, opcode
// encodings and instruction field positions, plus a halt predecoder.
package cpu_pkg;

    localparam int INST_W = 24;

    typedef enum logic [1:0] {
        OPT_ALU = 2'b00,
        OPT_IMM = 2'b01,
        OPT_JMP = 2'b10,
        OPT_CTL = 2'b11
    } optype_e;

    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [3:0] OP_NOP  = 4'b0000;

    // Instruction layout: optype | op | rd | rs | rt
    localparam int OPTYPE_MSB = 23;
    localparam int OPTYPE_LSB = 22;
    localparam int OP_MSB     = 21;
    localparam int OP_LSB     = 18;
    localparam int RD_MSB     = 17;
    localparam int RD_LSB     = 12;
    localparam int RS_MSB     = 11;
    localparam int RS_LSB     = 6;
    localparam int RT_MSB     = 5;
    localparam int RT_LSB     = 0;

    function automatic logic is_halt(input logic [INST_W-1:0] word);
        return (optype_e'(word[OPTYPE_MSB:OPTYPE_LSB]) == OPT_CTL) &&
               (word[OP_MSB:OP_LSB] == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} entries for the fetch stage.
// Flush empties it in one cycle and overrides push/pop. The head output
// reads as zero while empty so it stays stable with nothing buffered.
module fetch_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointer and occupancy bookkeeping; flush wins over push/pop
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the count
    always_ff @(posedge ck) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: sequential PC generation, credit-limited reads
// to a synchronous instruction memory, and a prefetch FIFO drained by
// decode. Redirect flushes and restarts; halt stops new fetches for good.
// Optional build macro FETCH_HALT_DETECT_EN: predecode pushed instructions
// and stop fetching at a halt instruction, dropping the request behind it.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic              ck,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt_req,
    output logic              halted
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INST_W + PC_W;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [PC_W-1:0] fetch_pc_p0;
    logic            run_p0;
    logic            stop_p0;
    logic            req_vld_p1;
    logic [PC_W-1:0] req_pc_p1;

    logic            issue;
    logic            resp_live;
    logic            resp_kill;
    logic            halt_hit;
    logic            pop;
    logic [CW:0]     used;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   head;

    // Issue only while FIFO entries plus the outstanding read leave room
    always_comb begin
        used      = {1'b0, fifo_count} + {{CW{1'b0}}, req_vld_p1};
        issue     = run_p0 && !stop_p0 && !redirect_valid && (used < DEPTH_L);
        resp_live = req_vld_p1 && !redirect_valid && !resp_kill;
        pop       = !fifo_empty && inst_ready && !redirect_valid;
    end

`ifdef FETCH_HALT_DETECT_EN
    logic hd_stop_p0;

    assign halt_hit  = resp_live && is_halt(imem_rdata);
    assign resp_kill = hd_stop_p0;

    // Remember a predecoded halt so the read issued alongside it is dropped
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)        hd_stop_p0 <= 1'b0;
        else if (halt_hit) hd_stop_p0 <= 1'b1;
    end
`else
    assign halt_hit  = 1'b0;
    assign resp_kill = 1'b0;
`endif

    // Stage p0 -> p1: fetch PC, outstanding-read flag and sticky stop
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            run_p0      <= 1'b0;
            fetch_pc_p0 <= '0;
            req_vld_p1  <= 1'b0;
            stop_p0     <= 1'b0;
        end else begin
            run_p0     <= 1'b1;
            req_vld_p1 <= issue;
            if (redirect_valid)  fetch_pc_p0 <= redirect_pc;
            else if (issue)      fetch_pc_p0 <= fetch_pc_p0 + PC_W'(1);
            if (halt_req || halt_hit) stop_p0 <= 1'b1;
        end
    end

    // PC travelling with the outstanding read, paired with the returned word
    always_ff @(posedge ck) begin
        if (issue) req_pc_p1 <= fetch_pc_p0;
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck        (ck),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (resp_live),
        .push_data ({imem_rdata, req_pc_p1}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assert property (@(posedge ck) disable iff (!rst_n) !(resp_live && fifo_full));

    assign imem_req   = issue;
    assign imem_addr  = fetch_pc_p0;
    assign inst_valid = !fifo_empty;
    assign inst       = head[EW-1:PC_W];
    assign inst_pc    = head[PC_W-1:0];
    assign halted     = stop_p0 && fifo_empty && !req_vld_p1;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch with a queue-based reference model and a
// synchronous instruction memory model.
module tb_inst_fetch;
    import cpu_pkg::*;

    localparam int PC_W  = 32;
    localparam int DEPTH = 4;

    logic              ck = 1'b0;
    logic              rst_n;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt_req;
    logic              halted;

    always #5 ck = ~ck;

    inst_fetch #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .ck             (ck),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory contents: word k holds k xor salt; a halt word may be planted at 2
    logic [23:0] salt       = 24'h0;
    bit          plant_halt = 1'b0;

    function automatic logic [23:0] mem_f(input logic [31:0] a);
        logic [23:0] r;
        if (plant_halt && a == 32'd2) return 24'b11_1111_000000_000000_000000;
        r = a[23:0] ^ salt;
        if (r[23:18] == 6'h3F) r[23] = 1'b0;
        return r;
    endfunction

    typedef struct packed {
        logic [23:0] ins;
        logic [31:0] pc;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_inf_pc;
    bit          m_inf;
    bit          m_stop;
    bit          m_kill;
    bit          m_run;

    // Memory-side state and delivery log
    bit          resp_pending;
    logic [31:0] resp_addr;
    logic [31:0] dlv[$];

    function automatic logic [31:0] dget(input int i);
        if (i < dlv.size()) return dlv[i];
        return 'x;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc         = '0;
        m_inf_pc     = '0;
        m_inf        = 1'b0;
        m_stop       = 1'b0;
        m_kill       = 1'b0;
        m_run        = 1'b0;
        resp_pending = 1'b0;
        resp_addr    = '0;
    endtask

    // One clock cycle: drive memory data, compare, advance model, step clock
    task automatic cycle();
        bit   e_req;
        bit   e_valid;
        bit   e_halted;
        ent_t nw;
        imem_rdata = resp_pending ? mem_f(resp_addr) : 24'($urandom);
        #1;
        e_req    = m_run && !m_stop && !redirect_valid && (mq.size() + int'(m_inf) < DEPTH);
        e_valid  = (mq.size() != 0);
        e_halted = m_stop && (mq.size() == 0) && !m_inf;
        check("imem_req", imem_req, e_req);
        if (e_req) check("imem_addr", imem_addr, m_pc);
        check("inst_valid", inst_valid, e_valid);
        if (e_valid) begin
            check("inst", inst, mq[0].ins);
            check("inst_pc", inst_pc, mq[0].pc);
        end
        check("halted", halted, e_halted);
        if (inst_valid && inst_ready && !redirect_valid) dlv.push_back(inst_pc);
        resp_pending = imem_req;
        resp_addr    = imem_addr;

        if (redirect_valid) begin
            mq.delete();
            m_pc  = redirect_pc;
            m_inf = 1'b0;
        end else begin
            if (e_valid && inst_ready) void'(mq.pop_front());
            if (m_inf && !m_kill) begin
                nw.ins = mem_f(m_inf_pc);
                nw.pc  = m_inf_pc;
                mq.push_back(nw);
`ifdef FETCH_HALT_DETECT_EN
                if (nw.ins[23:22] == 2'b11 && nw.ins[21:18] == 4'hF) begin
                    m_stop = 1'b1;
                    m_kill = 1'b1;
                end
`endif
            end
            m_inf    = e_req;
            m_inf_pc = m_pc;
            if (e_req) m_pc = m_pc + 32'd1;
        end
        if (halt_req) m_stop = 1'b1;
        m_run = 1'b1;
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic reset_phase();
        @(negedge ck);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        inst_ready     = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 24'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_halted", halted, 1'b0);
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        imem_rdata     = '0;
        model_reset();

        reset_phase();

        // Streaming with memory[k] = k
        inst_ready = 1'b1;
        dlv.delete();
        repeat (12) cycle();
        check("stream_pc0", dget(0), 32'd0);
        check("stream_pc1", dget(1), 32'd1);
        check("stream_pc5", dget(5), 32'd5);

        // Decode stalls long enough to fill the FIFO
        inst_ready = 1'b0;
        repeat (10) cycle();
        check("stall_req_drop", imem_req, 1'b0);
        check("stall_valid", inst_valid, 1'b1);
        inst_ready = 1'b1;
        dlv.delete();
        repeat (8) cycle();
        for (int i = 1; i < 5; i++) check("stall_no_gap", dget(i), dget(0) + 32'(i));

        // Redirect with three entries buffered and a read outstanding
        salt       = 24'h5A5A5A;
        inst_ready = 1'b0;
        for (int w = 0; w < 10 && !(mq.size() == 3 && m_inf); w++) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        dlv.delete();
        cycle();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        check("rdr_valid_r1", inst_valid, 1'b0);
        cycle();
        check("rdr_valid_r2", inst_valid, 1'b0);
        cycle();
        check("rdr_valid_r3", inst_valid, 1'b1);
        repeat (5) cycle();
        check("rdr_first_pc", dget(0), 32'h40);
        check("rdr_second_pc", dget(1), 32'h41);

        // Random traffic with redirects, some near the PC wrap point
        for (int i = 0; i < 300; i++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ?
                             (32'hFFFF_FFFD + 32'($urandom_range(0, 2))) : $urandom;
            cycle();
        end
        redirect_valid = 1'b0;

        // PC wraps silently from all-ones to zero
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        dlv.delete();
        repeat (8) cycle();
        check("wrap_pc0", dget(0), 32'hFFFF_FFFE);
        check("wrap_pc1", dget(1), 32'hFFFF_FFFF);
        check("wrap_pc2", dget(2), 32'h0);
        check("wrap_pc3", dget(3), 32'h1);

        // halt_req mid-stream, then a redirect that must not restart fetch
        for (int i = 0; i < 6; i++) begin
            inst_ready = ($urandom_range(0, 1) != 0);
            cycle();
        end
        halt_req = 1'b1;
        cycle();
        halt_req   = 1'b0;
        inst_ready = 1'b1;
        repeat (12) cycle();
        check("halt_halted", halted, 1'b1);
        check("halt_no_req", imem_req, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        repeat (5) cycle();
        check("halt_rdr_no_req", imem_req, 1'b0);
        check("halt_rdr_halted", halted, 1'b1);

        // Halt instruction planted at address 2
        reset_phase();
        salt       = 24'h0;
        plant_halt = 1'b1;
        inst_ready = 1'b1;
        dlv.delete();
        repeat (20) cycle();
        check("hd_pc0", dget(0), 32'd0);
        check("hd_pc2", dget(2), 32'd2);
`ifdef FETCH_HALT_DETECT_EN
        check("hd_halted", halted, 1'b1);
        check("hd_delivered", 32'(dlv.size()), 32'd3);
`else
        check("hd_off_halted", halted, 1'b0);
        check("hd_off_pc3", dget(3), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
